// File: rtl/physics_pkg.sv
// ---------------------------------------------------------------------------
// physics_pkg
// Shared types and constants for the physics step scheduler.
//   sched_state_t : scheduler FSM state encoding
//   STAGE_*       : stage-engine indices in their fixed launch order
// ---------------------------------------------------------------------------
package physics_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } sched_state_t;

    // Stage engines in launch order; index 0 runs first in every substep.
    localparam int unsigned STAGE_SPRINGS   = 0;
    localparam int unsigned STAGE_COLLIDE   = 1;
    localparam int unsigned STAGE_INTEGRATE = 2;

endpackage : physics_pkg

// File: rtl/stage_watchdog.sv
// ---------------------------------------------------------------------------
// stage_watchdog
// Per-stage hang detector for the physics step scheduler. Implemented as a
// down-counter with a terminal-count compare: loading TIMEOUT_CYCLES-1 and
// counting down to zero is equivalent to an up-count from 0 reaching
// TIMEOUT_CYCLES-1.
//
// Ports:
//   clk_in      : system clock
//   rst_in      : asynchronous active-low reset
//   clear_in    : reload the counter (held during the stage launch cycle)
//   enable_in   : count one cycle (held while waiting on the stage)
//   expired_out : high once TIMEOUT_CYCLES-1 wait cycles have elapsed, i.e.
//                 during the TIMEOUT_CYCLES-th wait cycle
// ---------------------------------------------------------------------------
module stage_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expired_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] remain_d;

    always_comb begin
        remain_d = remain_q;
        if (clear_in) begin
            remain_d = LOAD_VAL;
        end else if (enable_in && (remain_q != '0)) begin
            // Hold at zero so the terminal count never wraps.
            remain_d = remain_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            remain_q <= LOAD_VAL;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign expired_out = (remain_q == '0);

endmodule : stage_watchdog

// File: rtl/physics_step_scheduler.sv
// ---------------------------------------------------------------------------
// physics_step_scheduler
// Per-frame sequencer for the physics datapath. Each accepted frame tick
// runs every stage engine in index order, SUBSTEPS times over. Each stage
// receives a one-cycle start pulse and the scheduler waits for that stage's
// done pulse. A watchdog aborts the step if a stage hangs, and ticks that
// arrive while a step is in progress are counted as overruns.
//
// Ports:
//   clk_in           : system clock
//   rst_in           : asynchronous active-low reset
//   frame_tick_in    : one-cycle request for a physics step
//   enable_in        : gates acceptance of frame_tick_in (and overrun count)
//   clear_err_in     : clears timeout_err_out / err_stage_out
//   stage_done_in    : per-stage done pulses
//   stage_start_out  : one-hot, one-cycle start pulse to the current stage
//   busy_out         : high whenever the scheduler is not idle
//   cur_stage_out    : stage currently launched / awaited
//   cur_substep_out  : current substep index
//   step_done_out    : one-cycle pulse when all substeps have completed
//   timeout_err_out  : sticky watchdog abort flag
//   err_stage_out    : stage that timed out, latched with the flag
//   overrun_cnt_out  : saturating count of ticks dropped while busy
//
// States:
//   IDLE   | waiting for an enabled frame tick
//   LAUNCH | start pulse to current stage, watchdog reloaded (1 cycle)
//   WAIT   | waiting for current stage's done, watchdog running
//   NEXT   | advance stage / substep, or finish (1 cycle)
//   DONE   | step_done pulse, then back to IDLE (1 cycle)
//
// All outputs are flops whose next value is derived from the next state, so
// each output lines up with the state it describes in the same cycle.
// ---------------------------------------------------------------------------
module physics_step_scheduler
    import physics_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned SUBSTEPS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned OVR_W          = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          frame_tick_in,
    input  logic                          enable_in,
    input  logic                          clear_err_in,
    input  logic [NUM_STAGES-1:0]         stage_done_in,
    output logic [NUM_STAGES-1:0]         stage_start_out,
    output logic                          busy_out,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage_out,
    output logic [$clog2(SUBSTEPS):0]     cur_substep_out,
    output logic                          step_done_out,
    output logic                          timeout_err_out,
    output logic [$clog2(NUM_STAGES)-1:0] err_stage_out,
    output logic [OVR_W-1:0]              overrun_cnt_out
);

    localparam int unsigned STG_W = $clog2(NUM_STAGES);
    localparam int unsigned SUB_W = $clog2(SUBSTEPS) + 1;

    localparam logic [STG_W-1:0] LAST_STAGE   = STG_W'(NUM_STAGES - 1);
    localparam logic [SUB_W-1:0] LAST_SUBSTEP = SUB_W'(SUBSTEPS - 1);

    sched_state_t          state_q,     state_d;
    logic [STG_W-1:0]      stage_q,     stage_d;
    logic [SUB_W-1:0]      substep_q,   substep_d;
    logic [NUM_STAGES-1:0] start_q,     start_d;
    logic                  busy_q,      busy_d;
    logic                  step_done_q, step_done_d;
    logic                  err_q,       err_d;
    logic [STG_W-1:0]      err_stage_q, err_stage_d;
    logic [OVR_W-1:0]      ovr_q,       ovr_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;
    logic done_hit;

    assign wd_clear  = (state_q == LAUNCH);
    assign wd_enable = (state_q == WAIT);

    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stage_watchdog (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_in    (wd_clear),
        .enable_in   (wd_enable),
        .expired_out (wd_expired)
    );

    // Only the awaited stage's done bit counts; stray pulses on other bits
    // are masked off here.
    assign done_hit = |(stage_done_in & (NUM_STAGES'(1) << stage_q));

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        substep_d   = substep_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        ovr_d       = ovr_q;

        if (clear_err_in) begin
            err_d       = 1'b0;
            err_stage_d = '0;
        end

        if (frame_tick_in && enable_in && (state_q != IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (frame_tick_in && enable_in) begin
                    stage_d   = '0;
                    substep_d = '0;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Done is checked first so a done arriving on the last
                // watchdog cycle still advances.
                if (done_hit) begin
                    state_d = NEXT;
                end else if (wd_expired) begin
                    state_d     = IDLE;
                    err_d       = 1'b1;
                    err_stage_d = stage_q;
                end
            end
            NEXT: begin
                if (stage_q != LAST_STAGE) begin
                    stage_d = stage_q + STG_W'(1);
                    state_d = LAUNCH;
                end else if (substep_q != LAST_SUBSTEP) begin
                    substep_d = substep_q + SUB_W'(1);
                    stage_d   = '0;
                    state_d   = LAUNCH;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d     = (state_d == LAUNCH) ? (NUM_STAGES'(1) << stage_d) : '0;
        busy_d      = (state_d != IDLE);
        step_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            substep_q   <= '0;
            start_q     <= '0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            substep_q   <= substep_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            step_done_q <= step_done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            ovr_q       <= ovr_d;
        end
    end

    assign stage_start_out = start_q;
    assign busy_out        = busy_q;
    assign cur_stage_out   = stage_q;
    assign cur_substep_out = substep_q;
    assign step_done_out   = step_done_q;
    assign timeout_err_out = err_q;
    assign err_stage_out   = err_stage_q;
    assign overrun_cnt_out = ovr_q;

endmodule : physics_step_scheduler
